// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-side stage of the multicycle datapath. It turns the control unit's
// MemRead/MemWrite strobes into exactly one req/ack bus transaction. It holds
// the control FSM through oStall until the transaction completes. It owns the
// instruction register (IR) and the memory data register (MDR). It also does
// load byte/half extraction with sign/zero extension, and store byte-lane
// steering.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction after TIMEOUT
// BUSY cycles without ack (sets sticky oBusErr). When undefined, BUSY waits
// indefinitely and oBusErr is tied low.
//
// Ports:
//   iCLK, iRST_n        clock (rising edge), synchronous active-low reset
//   iMemRead/iMemWrite  request levels from control (read wins if both)
//   iIRWrite            read completion targets IR instead of MDR
//   iIorD               address select: 0 = iPC, 1 = iALUOut
//   iPC, iALUOut        instruction / data address
//   iStoreData          store source
//   iLoadCase           000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others lw
//   iWriteCase          00 sw, 01 sh, 10 sb, 11 sw
//   oStall              control must hold its state
//   oIR, oMDR           instruction register, extended load data
//   oBusAddr/WData/BE   word-aligned address, steered data, byte enables
//   oBusRead/oBusWrite  registered bus strobes
//   iBusRData, iBusAck  read data, one-cycle completion
//   oMisalign, oBusErr  sticky misaligned-access / timeout flags
//   oState              current state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] IR_RESET = 32'h00000013
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iIRWrite,
    input  logic        iIorD,
    input  logic [31:0] iPC,
    input  logic [31:0] iALUOut,
    input  logic [31:0] iStoreData,
    input  logic [2:0]  iLoadCase,
    input  logic [1:0]  iWriteCase,
    output logic        oStall,
    output logic [31:0] oIR,
    output logic [31:0] oMDR,
    output logic [31:0] oBusAddr,
    output logic [31:0] oBusWData,
    output logic [3:0]  oBusBE,
    output logic        oBusRead,
    output logic        oBusWrite,
    input  logic [31:0] iBusRData,
    input  logic        iBusAck,
    output logic        oMisalign,
    output logic        oBusErr,
    output logic [1:0]  oState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [1:0]  off_reg;
    logic [2:0]  lcase_reg;
    logic        irw_reg;
    logic [31:0] ir_reg;
    logic [31:0] mdr_reg;
    logic [31:0] bus_addr_reg;
    logic [31:0] bus_wdata_reg;
    logic [3:0]  bus_be_reg;
    logic        bus_read_reg;
    logic        bus_write_reg;
    logic        misalign_reg;

    logic [31:0] addr;
    logic        req;
    logic        misaligned;
    logic        accept;
    logic        timeout_hit;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    assign addr   = iIorD ? iALUOut : iPC;
    assign req    = iMemRead | iMemWrite;
    assign accept = (state_reg == IDLE) && req && !misaligned;

    // Alignment is checked against whichever access wins: a read if requested,
    // otherwise the write.
    always_comb begin
        misaligned = 1'b0;
        if (iMemRead) begin
            case (iLoadCase)
                3'b001, 3'b010: misaligned = addr[0];
                3'b011, 3'b100: misaligned = 1'b0;
                default:        misaligned = |addr[1:0];
            endcase
        end else begin
            case (iWriteCase)
                2'b01:   misaligned = addr[0];
                2'b10:   misaligned = 1'b0;
                default: misaligned = |addr[1:0];
            endcase
        end
    end

    // Store lane steering: halfword sits in the lane chosen by addr[1],
    // a byte is replicated so any byte-enable lane sees it.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = iStoreData;
        case (iWriteCase)
            2'b01: begin
                store_be    = 4'b0011 << addr[1:0];
                store_wdata = addr[1] ? {iStoreData[15:0], 16'h0000}
                                      : {16'h0000, iStoreData[15:0]};
            end
            2'b10: begin
                store_be    = 4'b0001 << addr[1:0];
                store_wdata = {4{iStoreData[7:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = iStoreData;
            end
        endcase
    end

    // Load extraction uses the offset and case latched at accept time.
    always_comb begin
        case (off_reg)
            2'd0:    load_byte = iBusRData[7:0];
            2'd1:    load_byte = iBusRData[15:8];
            2'd2:    load_byte = iBusRData[23:16];
            default: load_byte = iBusRData[31:24];
        endcase
        load_half = off_reg[1] ? iBusRData[31:16] : iBusRData[15:0];
        case (lcase_reg)
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b010:  load_ext = {16'h0000, load_half};
            3'b011:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_ext = {24'h000000, load_byte};
            default: load_ext = iBusRData;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [4:0] tcount_reg;
    logic       bus_err_reg;

    // Ack on the limit cycle takes priority over the abort.
    assign timeout_hit = (state_reg == BUSY) && !iBusAck
                         && (tcount_reg == 5'(TIMEOUT - 1));

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            tcount_reg  <= 5'd0;
            bus_err_reg <= 1'b0;
        end else begin
            if (accept) begin
                tcount_reg <= 5'd0;
            end else if ((state_reg == BUSY) && !iBusAck) begin
                tcount_reg <= tcount_reg + 5'd1;
            end
            if (timeout_hit) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    assign oBusErr = bus_err_reg;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign oBusErr        = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_reg     <= IDLE;
            off_reg       <= 2'd0;
            lcase_reg     <= 3'd0;
            irw_reg       <= 1'b0;
            ir_reg        <= IR_RESET;
            mdr_reg       <= 32'h0;
            bus_addr_reg  <= 32'h0;
            bus_wdata_reg <= 32'h0;
            bus_be_reg    <= 4'h0;
            bus_read_reg  <= 1'b0;
            bus_write_reg <= 1'b0;
            misalign_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req && misaligned) begin
                        misalign_reg <= 1'b1;
                    end else if (accept) begin
                        off_reg       <= addr[1:0];
                        lcase_reg     <= iLoadCase;
                        irw_reg       <= iIRWrite;
                        bus_addr_reg  <= {addr[31:2], 2'b00};
                        bus_read_reg  <= iMemRead;
                        bus_write_reg <= !iMemRead;
                        bus_be_reg    <= iMemRead ? 4'b1111 : store_be;
                        bus_wdata_reg <= iMemRead ? 32'h0 : store_wdata;
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    if (iBusAck) begin
                        bus_read_reg  <= 1'b0;
                        bus_write_reg <= 1'b0;
                        state_reg     <= DONE;
                        if (bus_read_reg) begin
                            if (irw_reg) begin
                                ir_reg <= iBusRData;
                            end else begin
                                mdr_reg <= load_ext;
                            end
                        end
                    end else if (timeout_hit) begin
                        bus_read_reg  <= 1'b0;
                        bus_write_reg <= 1'b0;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign oStall    = accept || (state_reg == BUSY);
    assign oIR       = ir_reg;
    assign oMDR      = mdr_reg;
    assign oBusAddr  = bus_addr_reg;
    assign oBusWData = bus_wdata_reg;
    assign oBusBE    = bus_be_reg;
    assign oBusRead  = bus_read_reg;
    assign oBusWrite = bus_write_reg;
    assign oMisalign = misalign_reg;
    assign oState    = state_reg;

endmodule
